bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Two-master arbiter in front of the peripheral bridge bus (Bus_addr/Bus_wen/Bus_wdata/Bus_rdata).
- Shares the bus between master 0 (CPU data port) and master 1 (DMA/debug loader).
- Registered grant state machine with round-robin or fixed priority and locked bursts of bounded length.
- CPU stalls its PC while m0_req is high and m0_ack is low.

Parameters:
- ROUND_ROBIN, 1: 1 = alternate on contention; 0 = m0 always wins ties.
- MAX_BURST, 4: maximum consecutive locked beats before the owner must yield to a pending master (MAX_BURST ≥ 1).

Ports:
- cpu_clk  in  1  clock.
- cpu_rst  in  1  asynchronous reset, active-high.
- m0_req, m1_req  in  1  transaction request; held high, with addr/wen/wdata stable, until ack.
- m0_lock, m1_lock  in  1  owner wants the next beat as well (burst).
- m0_addr, m1_addr  in  32  address.
- m0_wen, m1_wen  in  1  write enable.
- m0_wdata, m1_wdata  in  32  write data.
- m0_rdata, m1_rdata  out  32  read data; valid only in the ack cycle.
- m0_ack, m1_ack  out  1  one-cycle beat completion.
- Bus_addr  out  32  to bridge.
- Bus_wen  out  1  to bridge.
- Bus_wdata  out  32  to bridge.
- Bus_rdata  in  32  bridge read data, combinational in the same cycle.

Behaviour:
- State register: IDLE, GNT0, GNT1. Also a last_owner bit and burst_cnt of width clog2(MAX_BURST)+1.
- Reset (async): state=IDLE, last_owner=1 (so m0 wins the first tie), burst_cnt=0.
- Outputs while reset is asserted, or in IDLE: all acks 0, Bus_* = 0, mX_rdata = 0.
- Reset mid-beat aborts the beat. No ack is issued and Bus_wen drops immediately.
- Bus mux is combinational from the state:
  - GNTx drives Bus_addr/Bus_wen/Bus_wdata from master x.
  - mx_rdata = Bus_rdata; the non-owner's rdata = 0.
- mx_ack = (state==GNTx) & mx_req.
- If mx_req is low in GNTx (protocol violation):
  - Bus_wen is forced to 0 and no ack is issued.
  - Next state is IDLE, or GNTy if the other master is requesting.
- IDLE next-state:
  - Only one master requesting → that master's GNT.
  - Both requesting, ROUND_ROBIN=1 → master != last_owner.
  - Both requesting, ROUND_ROBIN=0 → GNT0.
  - Neither → stay IDLE.
- Entering GNTx sets last_owner=x and burst_cnt=1.
- Latency: request first sampled at edge n → ack in cycle n+1, i.e. one wait cycle from IDLE.
- GNTx next-state, evaluated in the ack cycle:
  - a) mx_lock & (burst_cnt < MAX_BURST | ~my_req) → stay GNTx, burst_cnt+1 (saturating at MAX_BURST). Back-to-back beats, zero wait.
  - b) else if my_req → GNTy directly, burst_cnt=1. No idle bubble.
  - c) else → IDLE.
- Lock effectively ignored when MAX_BURST=1 and the other master is pending.
- Each beat is exactly one ack cycle.
- A write occurs on the bridge exactly once per acked beat with Bus_wen=1.

Optional Feature:
- Macro ARB_PERF_CNT_EN adds outputs perf_gnt0, perf_gnt1 (32 bits each) and perf_wait0 (32 bits).
  - perf_gnt0/perf_gnt1 count acked beats per master.
  - perf_wait0 counts cycles with m0_req & ~m0_ack.
  - Counters wrap at 2^32 and clear on cpu_rst.
- Without the macro these ports and registers do not exist. Arbitration behaviour is identical either way.

Test Plan:
- Single m0 read: m0_req=1, addr=0xFFFFF000, bridge rdata=0x12345678 → m0_ack=1 in the 2nd cycle, m0_rdata=0x12345678, Bus_wen=0; IDLE afterwards.
- Simultaneous requests from reset, ROUND_ROBIN=1, both unlocked with continuous requests → ack order m0, m1, m0, m1, one beat per cycle, no IDLE bubble. Same with ROUND_ROBIN=0 → m0 acked every cycle, m1 never acked.
- m1 locked burst, MAX_BURST=4, m0 requesting throughout → 4 consecutive m1 acks, then m0 acked on the 5th cycle. Same burst with m0 idle → m1 holds the bus for 6 beats.
- m0 write addr=0xFFFFF060, wdata=0xA5A5A5A5 while m1 idle → exactly one cycle with Bus_wen=1 and those values; Bus_wen=0 in IDLE.
- Assert cpu_rst mid-beat in GNT1 → same-cycle Bus_wen=0 and m1_ack=0. After release, a simultaneous m0/m1 request grants m0 first.
- With ARB_PERF_CNT_EN: 3 m0 beats and 2 m1 beats under contention → perf_gnt0=3, perf_gnt1=2, perf_wait0 equals the observed m0 stall cycles.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master arbiter for the peripheral bridge bus: round-robin or fixed priority, bounded bursts.
// Optional ARB_PERF_CNT_EN adds per-master beat counters and an m0 stall counter.
module bus_arbiter #(
  parameter bit          ROUND_ROBIN = 1'b1,
  parameter int unsigned MAX_BURST   = 4
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_lock,
  input  logic        m1_lock,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic        m0_wen,
  input  logic        m1_wen,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        m0_ack,
  output logic        m1_ack,
  output logic [31:0] Bus_addr,
  output logic        Bus_wen,
  output logic [31:0] Bus_wdata,
  input  logic [31:0] Bus_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0] perf_gnt0,
  output logic [31:0] perf_gnt1,
  output logic [31:0] perf_wait0
`endif
);

  localparam int unsigned     CntW   = $clog2(MAX_BURST) + 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_BURST);
  localparam logic [CntW-1:0] OneCnt = CntW'(1);

  typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

  state_e          state_q;
  logic            last_owner_q;
  logic [CntW-1:0] burst_cnt_q;
  logic            gnt0, gnt1;

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q      <= StIdle;
      last_owner_q <= 1'b1;
      burst_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (m0_req && (!m1_req || !ROUND_ROBIN || last_owner_q)) begin
            state_q      <= StGnt0;
            last_owner_q <= 1'b0;
            burst_cnt_q  <= OneCnt;
          end else if (m1_req) begin
            state_q      <= StGnt1;
            last_owner_q <= 1'b1;
            burst_cnt_q  <= OneCnt;
          end
        end
        StGnt0: begin
          if (!m0_req) begin
            if (m1_req) begin
              state_q      <= StGnt1;
              last_owner_q <= 1'b1;
              burst_cnt_q  <= OneCnt;
            end else begin
              state_q <= StIdle;
            end
          end else if (m0_lock && (burst_cnt_q < MaxCnt || !m1_req)) begin
            if (burst_cnt_q != MaxCnt) burst_cnt_q <= burst_cnt_q + OneCnt;
          end else if (m1_req && ROUND_ROBIN) begin
            state_q      <= StGnt1;
            last_owner_q <= 1'b1;
            burst_cnt_q  <= OneCnt;
          end else if (m1_req) begin
            // Fixed priority: m0 wins the tie again, counted as a fresh grant.
            burst_cnt_q <= OneCnt;
          end else begin
            state_q <= StIdle;
          end
        end
        StGnt1: begin
          if (!m1_req) begin
            if (m0_req) begin
              state_q      <= StGnt0;
              last_owner_q <= 1'b0;
              burst_cnt_q  <= OneCnt;
            end else begin
              state_q <= StIdle;
            end
          end else if (m1_lock && (burst_cnt_q < MaxCnt || !m0_req)) begin
            if (burst_cnt_q != MaxCnt) burst_cnt_q <= burst_cnt_q + OneCnt;
          end else if (m0_req) begin
            state_q      <= StGnt0;
            last_owner_q <= 1'b0;
            burst_cnt_q  <= OneCnt;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Gate with reset so an aborted beat drops the bus in the same cycle.
  always_comb begin
    gnt0      = (state_q == StGnt0) && !cpu_rst;
    gnt1      = (state_q == StGnt1) && !cpu_rst;
    m0_ack    = gnt0 && m0_req;
    m1_ack    = gnt1 && m1_req;
    Bus_addr  = '0;
    Bus_wdata = '0;
    Bus_wen   = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    if (gnt0) begin
      Bus_addr  = m0_addr;
      Bus_wdata = m0_wdata;
      Bus_wen   = m0_wen && m0_req;
      m0_rdata  = Bus_rdata;
    end else if (gnt1) begin
      Bus_addr  = m1_addr;
      Bus_wdata = m1_wdata;
      Bus_wen   = m1_wen && m1_req;
      m1_rdata  = Bus_rdata;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_gnt0_q, perf_gnt1_q, perf_wait0_q;

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      perf_gnt0_q  <= '0;
      perf_gnt1_q  <= '0;
      perf_wait0_q <= '0;
    end else begin
      if (m0_ack)            perf_gnt0_q  <= perf_gnt0_q + 32'd1;
      if (m1_ack)            perf_gnt1_q  <= perf_gnt1_q + 32'd1;
      if (m0_req && !m0_ack) perf_wait0_q <= perf_wait0_q + 32'd1;
    end
  end

  assign perf_gnt0  = perf_gnt0_q;
  assign perf_gnt1  = perf_gnt1_q;
  assign perf_wait0 = perf_wait0_q;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a round-robin instance and a fixed-priority instance share stimulus.
module tb_bus_arbiter;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        m0_req, m1_req, m0_lock, m1_lock, m0_wen, m1_wen;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, Bus_rdata;

  logic [31:0] rr_m0_rdata, rr_m1_rdata, rr_bus_addr, rr_bus_wdata;
  logic        rr_m0_ack, rr_m1_ack, rr_bus_wen;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_bus_addr, fp_bus_wdata;
  logic        fp_m0_ack, fp_m1_ack, fp_bus_wen;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] rr_perf_gnt0, rr_perf_gnt1, rr_perf_wait0;
  logic [31:0] fp_perf_gnt0, fp_perf_gnt1, fp_perf_wait0;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 cpu_clk = ~cpu_clk;

  bus_arbiter #(.ROUND_ROBIN(1'b1), .MAX_BURST(4)) dut_rr (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .m0_req(m0_req), .m1_req(m1_req), .m0_lock(m0_lock), .m1_lock(m1_lock),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wen(m0_wen), .m1_wen(m1_wen),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_rdata(rr_m0_rdata), .m1_rdata(rr_m1_rdata),
    .m0_ack(rr_m0_ack), .m1_ack(rr_m1_ack),
    .Bus_addr(rr_bus_addr), .Bus_wen(rr_bus_wen), .Bus_wdata(rr_bus_wdata),
    .Bus_rdata(Bus_rdata)
`ifdef ARB_PERF_CNT_EN
    , .perf_gnt0(rr_perf_gnt0), .perf_gnt1(rr_perf_gnt1), .perf_wait0(rr_perf_wait0)
`endif
  );

  bus_arbiter #(.ROUND_ROBIN(1'b0), .MAX_BURST(4)) dut_fp (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .m0_req(m0_req), .m1_req(m1_req), .m0_lock(m0_lock), .m1_lock(m1_lock),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wen(m0_wen), .m1_wen(m1_wen),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_rdata(fp_m0_rdata), .m1_rdata(fp_m1_rdata),
    .m0_ack(fp_m0_ack), .m1_ack(fp_m1_ack),
    .Bus_addr(fp_bus_addr), .Bus_wen(fp_bus_wen), .Bus_wdata(fp_bus_wdata),
    .Bus_rdata(Bus_rdata)
`ifdef ARB_PERF_CNT_EN
    , .perf_gnt0(fp_perf_gnt0), .perf_gnt1(fp_perf_gnt1), .perf_wait0(fp_perf_wait0)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_req = 1'b0; m1_req = 1'b0; m0_lock = 1'b0; m1_lock = 1'b0;
    m0_wen = 1'b0; m1_wen = 1'b0;
    m0_addr = 32'h0000_0100; m1_addr = 32'h0000_0200;
    m0_wdata = 32'h0; m1_wdata = 32'h0; Bus_rdata = 32'hCAFE_F00D;
  endtask

  task automatic do_reset();
    cpu_rst = 1'b1;
    clear_inputs();
    step();
    cpu_rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cpu_rst = 1'b1;
    clear_inputs();
    step();
    // Requests during reset must not reach the bus.
    m0_req = 1'b1; m0_wen = 1'b1; m0_addr = 32'hDEAD_0000;
    #1;
    chk("rst_m0_ack", rr_m0_ack, 0);
    chk("rst_bus_wen", rr_bus_wen, 0);
    chk("rst_bus_addr", rr_bus_addr, 0);
    chk("rst_m0_rdata", rr_m0_rdata, 0);
    clear_inputs();
    cpu_rst = 1'b0;

    // Single m0 read.
    m0_req = 1'b1; m0_addr = 32'hFFFF_F000; Bus_rdata = 32'h1234_5678;
    #1;
    chk("rd_wait_ack", rr_m0_ack, 0);
    chk("rd_wait_addr", rr_bus_addr, 0);
    step(); #1;
    chk("rd_ack", rr_m0_ack, 1);
    chk("rd_rdata", rr_m0_rdata, 32'h1234_5678);
    chk("rd_addr", rr_bus_addr, 32'hFFFF_F000);
    chk("rd_wen", rr_bus_wen, 0);
    chk("rd_m1_rdata", rr_m1_rdata, 0);
    step();
    m0_req = 1'b0;
    #1;
    chk("rd_idle_ack", rr_m0_ack, 0);
    chk("rd_idle_addr", rr_bus_addr, 0);
    chk("rd_idle_rdata", rr_m0_rdata, 0);

    // Single m0 write.
    m0_req = 1'b1; m0_wen = 1'b1; m0_addr = 32'hFFFF_F060; m0_wdata = 32'hA5A5_A5A5;
    #1;
    chk("wr_wait_wen", rr_bus_wen, 0);
    step(); #1;
    chk("wr_wen", rr_bus_wen, 1);
    chk("wr_addr", rr_bus_addr, 32'hFFFF_F060);
    chk("wr_wdata", rr_bus_wdata, 32'hA5A5_A5A5);
    chk("wr_ack", rr_m0_ack, 1);
    step();
    m0_req = 1'b0; m0_wen = 1'b0;
    #1;
    chk("wr_idle_wen", rr_bus_wen, 0);

    // Contention from reset: alternation (RR) vs m0 always (fixed).
    do_reset();
    m0_req = 1'b1; m1_req = 1'b1;
    #1;
    chk("cont_idle_m0", rr_m0_ack, 0);
    chk("cont_idle_m1", rr_m1_ack, 0);
    for (int i = 1; i <= 4; i++) begin
      step(); #1;
      chk($sformatf("rr_m0_ack_%0d", i), rr_m0_ack, (i % 2 == 1) ? 1 : 0);
      chk($sformatf("rr_m1_ack_%0d", i), rr_m1_ack, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("rr_addr_%0d", i), rr_bus_addr,
          (i % 2 == 1) ? 32'h0000_0100 : 32'h0000_0200);
      chk($sformatf("fp_m0_ack_%0d", i), fp_m0_ack, 1);
      chk($sformatf("fp_m1_ack_%0d", i), fp_m1_ack, 0);
    end

    // m1 locked burst with m0 pending: four m1 beats, then m0.
    do_reset();
    m1_req = 1'b1; m1_lock = 1'b1;
    #1;
    chk("bst_wait", rr_m1_ack, 0);
    step();
    m0_req = 1'b1;
    #1;
    chk("bst_m1_1", rr_m1_ack, 1);
    for (int i = 2; i <= 4; i++) begin
      step(); #1;
      chk($sformatf("bst_m1_%0d", i), rr_m1_ack, 1);
      chk($sformatf("bst_m0_%0d", i), rr_m0_ack, 0);
    end
    step(); #1;
    chk("bst_m0_5", rr_m0_ack, 1);
    chk("bst_m1_5", rr_m1_ack, 0);

    // m1 locked burst with m0 idle: bus held for six beats.
    do_reset();
    m1_req = 1'b1; m1_lock = 1'b1;
    step();
    for (int i = 1; i <= 6; i++) begin
      if (i == 6) m1_lock = 1'b0;
      #1;
      chk($sformatf("lng_m1_%0d", i), rr_m1_ack, 1);
      step();
    end
    m1_req = 1'b0;
    #1;
    chk("lng_idle_ack", rr_m1_ack, 0);
    chk("lng_idle_addr", rr_bus_addr, 0);

    // Owner drops its request while granted: no ack, no write, hand over.
    do_reset();
    m0_req = 1'b1; m0_wen = 1'b1;
    step();
    m0_req = 1'b0; m1_req = 1'b1;
    #1;
    chk("viol_m0_ack", rr_m0_ack, 0);
    chk("viol_wen", rr_bus_wen, 0);
    step(); #1;
    chk("viol_m1_ack", rr_m1_ack, 1);

    // Reset mid-beat in GNT1, then m0 wins the first tie.
    do_reset();
    m1_req = 1'b1; m1_wen = 1'b1; m1_addr = 32'hFFFF_F080;
    step(); #1;
    chk("abort_pre_ack", rr_m1_ack, 1);
    chk("abort_pre_wen", rr_bus_wen, 1);
    #1 cpu_rst = 1'b1;
    #1;
    chk("abort_wen", rr_bus_wen, 0);
    chk("abort_ack", rr_m1_ack, 0);
    step();
    cpu_rst = 1'b0;
    m1_wen = 1'b0; m0_req = 1'b1; m1_req = 1'b1;
    #1;
    chk("post_rst_wait", rr_m0_ack, 0);
    step(); #1;
    chk("post_rst_m0", rr_m0_ack, 1);
    chk("post_rst_m1", rr_m1_ack, 0);

`ifdef ARB_PERF_CNT_EN
    // Three m0 and two m1 beats under contention; m0 stalls in cycles 0, 2 and 4.
    do_reset();
    #1;
    chk("perf_clr_g0", rr_perf_gnt0, 0);
    chk("perf_clr_w0", rr_perf_wait0, 0);
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      if (i == 5) m1_req = 1'b0;
      step();
    end
    m0_req = 1'b0;
    step(); #1;
    chk("perf_gnt0", rr_perf_gnt0, 3);
    chk("perf_gnt1", rr_perf_gnt1, 2);
    chk("perf_wait0", rr_perf_wait0, 3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
